traffic_phase_fsm: RTL and testbench
====================================

Name: traffic_phase_fsm

Overview:
- Upstream sequencer for a two-way intersection (NS/EW). Steps through the signal phases and drives the lamp outputs.
- Publishes the current phase duration on timer_value for the downstream countdown/display stage.
- Keeps its own per-tick phase countdown, so phase timing is independent of the downstream stage.
- Also handles a latched pedestrian request and a night flashing mode.

Parameters:
- T_GREEN, 30, green duration in ticks (1..63)
- T_YELLOW, 3, yellow duration in ticks (1..63)
- T_ALLRED, 2, all-red clearance in ticks (1..63)
- T_WALK, 10, pedestrian walk duration in ticks (1..63)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- tick  in  1  one-cycle timebase strobe (nominally 1 Hz)
- enable  in  1  1 = run; 0 = freeze remaining and state
- ped_req  in  1  pedestrian button, level or pulse
- night_mode  in  1  request flashing-yellow operation
- ns_light  out  3  {red,yellow,green} for NS
- ew_light  out  3  {red,yellow,green} for EW
- ped_walk  out  1  walk lamp
- timer_value  out  6  duration of current phase; 0 in FLASH
- remaining  out  6  ticks left in current phase, including the current one
- phase_done  out  1  one-cycle pulse on every phase transition
- state  out  3  encoded state, for debug

Behaviour:
- All outputs are registered.
- States and encodings: AR_A=0, NS_G=1, NS_Y=2, AR_B=3, EW_G=4, EW_Y=5, PED=6, FLASH=7.
- Lamps per state:
  - AR_A, AR_B, PED: both red.
  - NS_G: NS green, EW red.
  - NS_Y: NS yellow, EW red.
  - EW_G: EW green, NS red.
  - EW_Y: EW yellow, NS red.
  - FLASH: both yellow when flash_ph=1, else both 3'b000.
  - ped_walk=1 only in PED.
- Reset, while rst_n=0 at a clk edge:
  - state=AR_A, remaining=T_ALLRED, timer_value=T_ALLRED.
  - ns_light=ew_light=3'b100, ped_walk=0, phase_done=0, ped_pending=0, flash_ph=0.
  - Reset mid-phase aborts immediately; no yellow is inserted.
- Phase countdown, timed states (all except FLASH):
  - On tick & enable with remaining>1: remaining decrements by 1.
  - On tick & enable with remaining==1: transition in that same edge.
    - Load next state; remaining and timer_value both take the next phase's duration.
    - phase_done=1 for exactly one cycle.
  - Each timed phase therefore lasts exactly its duration in ticks.
  - tick with enable=0 is ignored. No partial-tick accumulation.
- Transitions at phase end:
  - AR_A -> FLASH if night_mode=1, else NS_G.
  - NS_G -> NS_Y -> AR_B -> EW_G -> EW_Y.
  - EW_Y -> PED if ped_pending=1, else AR_A.
  - PED -> AR_A.
- Pedestrian latch:
  - ped_pending sets on any cycle with ped_req=1.
  - It clears on the edge that enters PED; clear wins over a same-cycle ped_req.
  - A request during PED after entry sets ped_pending and is served next cycle round.
- Night mode:
  - night_mode is sampled only at the end of AR_A; there is no mid-cycle abort.
  - Entering FLASH: remaining=0, timer_value=0, flash_ph=1.
  - In FLASH, each tick & enable:
    - night_mode=1: toggle flash_ph.
    - night_mode=0: go to AR_A with remaining=T_ALLRED, phase_done pulse.
  - ped_pending is retained while in FLASH.
- Width rules:
  - All durations are 6-bit.
  - remaining never wraps below 1 in timed states.
  - Parameter value 0 or >63 is illegal; assert in simulation.
- timer_value:
  - Changes only on phase transitions or reset, and is stable for the whole phase.
  - Consumers must use phase_done to detect phase boundaries, not value changes.

Test Plan (T_GREEN=5, T_YELLOW=2, T_ALLRED=1, T_WALK=4, tick every 4 clk):
1. Release reset, enable=1, no requests.
   - Phase sequence AR_A(1 tick) NS_G(5) NS_Y(2) AR_B(1) EW_G(5) EW_Y(2) AR_A.
   - 16 ticks per cycle; phase_done pulses 6 times.
   - timer_value sequence 1,5,2,1,5,2.
2. Single-cycle ped_req during NS_G.
   - After EW_Y: PED for 4 ticks with ped_walk=1, both lamps 3'b100, timer_value=4, then AR_A.
   - Next cycle round skips PED.
3. ped_req asserted on the exact edge entering PED.
   - ped_pending=0 after entry; the following round has no PED.
   - ped_req one cycle later sets ped_pending=1.
4. enable=0 for 3 ticks mid-NS_G at remaining=3.
   - remaining stays 3 and lamps hold.
   - After enable=1, NS_G ends after 3 more ticks.
5. night_mode=1 set during EW_G.
   - Cycle completes to AR_A, then FLASH with timer_value=0; yellow lamps toggle every tick.
   - night_mode=0: next tick goes to AR_A, remaining=1, then NS_G.
6. rst_n=0 for one clk mid-NS_Y.
   - Next edge: state=AR_A, remaining=1, both red, ped_pending=0.

Source files
------------

// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm: two-way intersection phase sequencer with pedestrian latch and night flashing mode.
module traffic_phase_fsm #(
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [5:0] timer_value,
  output logic [5:0] remaining,
  output logic       phase_done,
  output logic [2:0] state
);
  typedef enum logic [2:0] {AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y, PED, FLASH} state_t;

  if (T_GREEN < 1 || T_GREEN > 63 || T_YELLOW < 1 || T_YELLOW > 63 ||
      T_ALLRED < 1 || T_ALLRED > 63 || T_WALK < 1 || T_WALK > 63) begin : g_bad_param
    $error("traffic_phase_fsm: durations must be 1..63");
  end

  state_t cur, nxt;
  logic step, done, flash_ph, flash_n, ped_pending, pend_n;
  logic [5:0] rem_n, tv_n;
  logic [2:0] ns_n, ew_n;

  function automatic logic [5:0] dur(input state_t s);
    return (s == NS_G || s == EW_G) ? 6'(T_GREEN) :
           (s == NS_Y || s == EW_Y) ? 6'(T_YELLOW) :
           (s == PED) ? 6'(T_WALK) : (s == FLASH) ? 6'd0 : 6'(T_ALLRED);
  endfunction

  always_comb begin
    step = tick & enable;
    done = step & ((cur == FLASH) ? !night_mode : (remaining == 6'd1));
    nxt = cur;
    if (done) begin
      case (cur)
        AR_A:    nxt = night_mode ? FLASH : NS_G;
        NS_G:    nxt = NS_Y;
        NS_Y:    nxt = AR_B;
        AR_B:    nxt = EW_G;
        EW_G:    nxt = EW_Y;
        EW_Y:    nxt = ped_pending ? PED : AR_A;
        default: nxt = AR_A;
      endcase
    end
    rem_n = done ? dur(nxt) : (step && cur != FLASH) ? remaining - 6'd1 : remaining;
    tv_n = done ? dur(nxt) : timer_value;
    flash_n = done ? (nxt == FLASH) : (step && cur == FLASH) ? ~flash_ph : flash_ph;
    // entering PED consumes the request; a same-cycle press is absorbed by this service
    pend_n = (done && nxt == PED) ? 1'b0 : (ped_pending | ped_req);
    ns_n = (nxt == NS_G) ? 3'b001 : (nxt == NS_Y) ? 3'b010 :
           (nxt == FLASH) ? {1'b0, flash_n, 1'b0} : 3'b100;
    ew_n = (nxt == EW_G) ? 3'b001 : (nxt == EW_Y) ? 3'b010 :
           (nxt == FLASH) ? {1'b0, flash_n, 1'b0} : 3'b100;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur <= AR_A;
      remaining <= 6'(T_ALLRED);
      timer_value <= 6'(T_ALLRED);
      ns_light <= 3'b100;
      ew_light <= 3'b100;
      ped_walk <= 1'b0;
      phase_done <= 1'b0;
      ped_pending <= 1'b0;
      flash_ph <= 1'b0;
    end else begin
      cur <= nxt;
      remaining <= rem_n;
      timer_value <= tv_n;
      ns_light <= ns_n;
      ew_light <= ew_n;
      ped_walk <= (nxt == PED);
      phase_done <= done;
      ped_pending <= pend_n;
      flash_ph <= flash_n;
    end
  end

  assign state = cur;
endmodule

// File: tb/tb_traffic_phase_fsm.sv
// tb_traffic_phase_fsm: directed checks of phase sequencing, pedestrian latch, freeze, night mode and reset.
module tb_traffic_phase_fsm;
  logic clk = 0, rst_n = 0, tick = 0, enable = 1, ped_req = 0, night_mode = 0;
  logic [2:0] ns_light, ew_light, state;
  logic ped_walk, phase_done;
  logic [5:0] timer_value, remaining;
  int n_vec = 0, n_bad = 0, pdc = 0;
  logic pd;

  traffic_phase_fsm #(.T_GREEN(5), .T_YELLOW(2), .T_ALLRED(1), .T_WALK(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable), .ped_req(ped_req),
    .night_mode(night_mode), .ns_light(ns_light), .ew_light(ew_light), .ped_walk(ped_walk),
    .timer_value(timer_value), .remaining(remaining), .phase_done(phase_done), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one tick every 4 clocks; returns at the negedge right after the tick edge
  task automatic do_tick(input logic pr);
    repeat (3) @(negedge clk);
    tick = 1;
    ped_req = pr;
    @(negedge clk);
    tick = 0;
    ped_req = 0;
    pd = phase_done;
    if (phase_done) pdc++;
  endtask

  task automatic run_phase(input int st, input int len, input int ns, input int ew, input int pw, input logic last_pr);
    chk("state", 8'(state), 8'(st));
    chk("timer_value", 8'(timer_value), 8'(len));
    chk("remaining", 8'(remaining), 8'(len));
    chk("ns_light", 8'(ns_light), 8'(ns));
    chk("ew_light", 8'(ew_light), 8'(ew));
    chk("ped_walk", 8'(ped_walk), 8'(pw));
    for (int i = 0; i < len; i++) begin
      do_tick(i == len - 1 ? last_pr : 1'b0);
      if (i < len - 1) begin
        chk("remaining_dec", 8'(remaining), 8'(len - 1 - i));
        chk("phase_done_low", 8'(pd), 8'd0);
      end else chk("phase_done_pulse", 8'(pd), 8'd1);
    end
  endtask

  task automatic round(input logic pr_ns, input logic last_pr);
    run_phase(0, 1, 4, 4, 0, 0);
    if (pr_ns) begin
      ped_req = 1;
      @(negedge clk);
      ped_req = 0;
    end
    run_phase(1, 5, 1, 4, 0, 0);
    run_phase(2, 2, 2, 4, 0, 0);
    run_phase(3, 1, 4, 4, 0, 0);
    run_phase(4, 5, 4, 1, 0, 0);
    run_phase(5, 2, 4, 2, 0, last_pr);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_remaining", 8'(remaining), 8'd1);
    chk("rst_timer", 8'(timer_value), 8'd1);
    chk("rst_ns", 8'(ns_light), 8'd4);
    chk("rst_ew", 8'(ew_light), 8'd4);
    chk("rst_walk", 8'(ped_walk), 8'd0);
    chk("rst_done", 8'(phase_done), 8'd0);
    rst_n = 1;
    // plain cycle: six transitions
    pdc = 0;
    round(0, 0);
    chk("cycle_done_count", 8'(pdc), 8'd6);
    chk("cycle_back_ar_a", 8'(state), 8'd0);
    // served request, then no PED next round
    round(1, 0);
    run_phase(6, 4, 4, 4, 1, 0);
    chk("after_ped", 8'(state), 8'd0);
    round(0, 0);
    chk("no_repeat_ped", 8'(state), 8'd0);
    // request on the PED-entry edge is absorbed
    round(1, 1);
    chk("ped_entry", 8'(state), 8'd6);
    chk("pending_cleared", 8'(dut.ped_pending), 8'd0);
    run_phase(6, 4, 4, 4, 1, 0);
    round(0, 0);
    chk("entry_req_absorbed", 8'(state), 8'd0);
    round(1, 1);
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    chk("pending_relatched", 8'(dut.ped_pending), 8'd1);
    run_phase(6, 4, 4, 4, 1, 0);
    round(0, 0);
    chk("relatched_served", 8'(state), 8'd6);
    run_phase(6, 4, 4, 4, 1, 0);
    // freeze mid-green
    run_phase(0, 1, 4, 4, 0, 0);
    do_tick(0);
    do_tick(0);
    chk("pre_freeze_rem", 8'(remaining), 8'd3);
    enable = 0;
    for (int i = 0; i < 3; i++) do_tick(0);
    chk("freeze_rem", 8'(remaining), 8'd3);
    chk("freeze_state", 8'(state), 8'd1);
    chk("freeze_ns", 8'(ns_light), 8'd1);
    chk("freeze_done", 8'(pd), 8'd0);
    enable = 1;
    do_tick(0);
    do_tick(0);
    chk("resume_state", 8'(state), 8'd1);
    do_tick(0);
    chk("resume_end", 8'(state), 8'd2);
    chk("resume_done", 8'(pd), 8'd1);
    run_phase(2, 2, 2, 4, 0, 0);
    run_phase(3, 1, 4, 4, 0, 0);
    run_phase(4, 5, 4, 1, 0, 0);
    run_phase(5, 2, 4, 2, 0, 0);
    // night mode raised during the previous EW_G round is taken at the end of AR_A
    run_phase(0, 1, 4, 4, 0, 0);
    run_phase(1, 5, 1, 4, 0, 0);
    run_phase(2, 2, 2, 4, 0, 0);
    run_phase(3, 1, 4, 4, 0, 0);
    night_mode = 1;
    run_phase(4, 5, 4, 1, 0, 0);
    run_phase(5, 2, 4, 2, 0, 0);
    run_phase(0, 1, 4, 4, 0, 0);
    chk("flash_state", 8'(state), 8'd7);
    chk("flash_timer", 8'(timer_value), 8'd0);
    chk("flash_rem", 8'(remaining), 8'd0);
    chk("flash_ns_on", 8'(ns_light), 8'd2);
    chk("flash_ew_on", 8'(ew_light), 8'd2);
    do_tick(0);
    chk("flash_ns_off", 8'(ns_light), 8'd0);
    chk("flash_ew_off", 8'(ew_light), 8'd0);
    chk("flash_no_done", 8'(pd), 8'd0);
    do_tick(0);
    chk("flash_ns_on2", 8'(ns_light), 8'd2);
    night_mode = 0;
    do_tick(0);
    chk("unflash_state", 8'(state), 8'd0);
    chk("unflash_rem", 8'(remaining), 8'd1);
    chk("unflash_timer", 8'(timer_value), 8'd1);
    chk("unflash_done", 8'(pd), 8'd1);
    chk("unflash_ns", 8'(ns_light), 8'd4);
    do_tick(0);
    chk("unflash_ns_g", 8'(state), 8'd1);
    // reset mid-yellow with a request pending
    ped_req = 1;
    @(negedge clk);
    ped_req = 0;
    for (int i = 0; i < 5; i++) do_tick(0);
    chk("pre_rst_state", 8'(state), 8'd2);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_state", 8'(state), 8'd0);
    chk("mid_rst_rem", 8'(remaining), 8'd1);
    chk("mid_rst_ns", 8'(ns_light), 8'd4);
    chk("mid_rst_ew", 8'(ew_light), 8'd4);
    chk("mid_rst_pending", 8'(dut.ped_pending), 8'd0);
    round(0, 0);
    chk("post_rst_no_ped", 8'(state), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
